// File: rtl/cipher_encoder.sv
// cipher_encoder: streaming BCD additive cipher, enc=(p+k+j) mod 95, one char per cycle through a 1-deep output register
module cipher_encoder #(
  parameter int ENQLEN = 10,
  parameter int PASSLEN = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [8*PASSLEN-1:0] PASSWD,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [7:0]           IN_CHAR,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [7:0]           OUT_CHAR,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);
  localparam int PW = PASSLEN > 1 ? $clog2(PASSLEN) : 1;
  localparam int CW = ENQLEN > 1 ? $clog2(ENQLEN) : 1;
  localparam logic [7:0] J0 = 8'((PASSLEN / 10) * 16 + PASSLEN % 10);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [8*PASSLEN-1:0] pass_q, pass_sh;
  logic [PW-1:0] pidx;
  logic [CW-1:0] cnt;
  logic [7:0] j_q, k, enc;
  logic [11:0] sum, m1, m2;
  logic in_hs, out_hs, last_in, wrap, bad;
  function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
    logic [4:0] s;
    logic [1:0] c;
    c = 2'd0;
    bcd_add = '0;
    for (int d = 0; d < 3; d++) begin
      s = {1'b0, a[4*d+:4]} + {1'b0, b[4*d+:4]} + {3'b000, c};
      c = s >= 5'd20 ? 2'd2 : s >= 5'd10 ? 2'd1 : 2'd0;
      bcd_add[4*d+:4] = s >= 5'd20 ? 4'(s - 5'd20) : s >= 5'd10 ? 4'(s - 5'd10) : s[3:0];
    end
  endfunction
  function automatic logic ge95(input logic [11:0] v);
    return v[11:8] != 4'd0 || (v[7:4] == 4'd9 && v[3:0] >= 4'd5);
  endfunction
  function automatic logic [11:0] sub95(input logic [11:0] v);
    logic b0, b1;
    b0 = v[3:0] < 4'd5;
    b1 = {1'b0, v[7:4]} < 5'd9 + {4'd0, b0};
    return {v[11:8] - {3'b000, b1},
            b1 ? v[7:4] + 4'd1 - {3'b000, b0} : v[7:4] - 4'd9 - {3'b000, b0},
            b0 ? v[3:0] + 4'd5 : v[3:0] - 4'd5};
  endfunction
  always_comb begin
    pass_sh = pass_q << {pidx, 3'b000};
    k = pass_sh[8*PASSLEN-1 -: 8];
    sum = bcd_add(bcd_add({4'd0, IN_CHAR}, {4'd0, k}), {4'd0, j_q});
    m1 = ge95(sum) ? sub95(sum) : sum;
    m2 = ge95(m1) ? sub95(m1) : m1;
    enc = m2[7:0];
    bad = IN_CHAR[7:4] > 4'd9 || IN_CHAR[3:0] > 4'd9 || IN_CHAR > 8'h94;
    IN_READY = state == RUN && (!OUT_VALID || OUT_READY);
    in_hs = IN_READY && IN_VALID;
    out_hs = OUT_VALID && OUT_READY;
    last_in = cnt == CW'(ENQLEN - 1);
    wrap = pidx == PW'(PASSLEN - 1);
    BUSY = state != IDLE;
    DONE = state == DRAIN && out_hs;
    state_nx = state == IDLE ? (START ? RUN : IDLE)
             : state == RUN ? (in_hs && last_in ? DRAIN : RUN)
             : (out_hs ? IDLE : DRAIN);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pass_q <= '0;
      pidx <= '0;
      cnt <= '0;
      j_q <= J0;
      OUT_VALID <= 1'b0;
      OUT_CHAR <= 8'h00;
      ERR <= 1'b0;
    end else begin
      state <= state_nx;
      OUT_VALID <= in_hs || (OUT_VALID && !OUT_READY);
      if (state == IDLE && START) begin
        pass_q <= PASSWD;
        pidx <= '0;
        cnt <= '0;
        j_q <= J0;
        ERR <= 1'b0;
      end
      if (in_hs) begin
        pidx <= wrap ? '0 : pidx + 1'b1;
        j_q <= wrap ? J0 : j_q[3:0] == 4'd0 ? {j_q[7:4] - 4'd1, 4'd9} : {j_q[7:4], j_q[3:0] - 4'd1};
        cnt <= last_in ? '0 : cnt + 1'b1;
        OUT_CHAR <= enc;
        ERR <= ERR || bad;
      end
    end
  end
endmodule

// File: tb/tb_cipher_encoder.sv
// tb_cipher_encoder: directed stimulus, decimal reference model with per-cycle compare plus literal pins
module tb_cipher_encoder;
  localparam int ENQLEN = 10;
  localparam int PASSLEN = 5;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [8*PASSLEN-1:0] passwd = '0;
  logic [7:0] in_char = 8'h00;
  logic in_ready, out_valid, busy, done, err;
  logic [7:0] out_char;
  int n_cmp = 0, n_bad = 0, n_done = 0, m_i = 0, m_out = 0;
  bit armed = 0, m_active = 0, m_err = 0;
  logic [8*PASSLEN-1:0] m_pw = '0;
  logic [7:0] q[$];
  cipher_encoder #(.ENQLEN(ENQLEN), .PASSLEN(PASSLEN)) dut (
    .CLK(clk), .RST(rst), .START(start), .PASSWD(passwd),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_CHAR(in_char),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_CHAR(out_char),
    .BUSY(busy), .DONE(done), .ERR(err)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int dec(logic [7:0] c);
    return int'(c[7:4]) * 10 + int'(c[3:0]);
  endfunction
  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) % 10) * 16 + v % 10);
  endfunction
  function automatic logic [7:0] enc_of(logic [7:0] c, logic [8*PASSLEN-1:0] pw, int i);
    int ki;
    logic [7:0] kb;
    ki = i % PASSLEN;
    kb = 8'(pw >> (8 * (PASSLEN - 1 - ki)));
    return bcd((dec(c) + dec(kb) + PASSLEN - ki) % 95);
  endfunction
  always @(negedge clk) begin
    bit exp_ir, exp_ov, out_hs, exp_done;
    if (rst) begin
      armed = 1;
      m_active = 0;
      m_err = 0;
      m_i = 0;
      m_out = 0;
      q.delete();
    end else if (armed) begin
      exp_ir = m_active && m_i < ENQLEN && (q.size() == 0 || out_ready);
      exp_ov = q.size() != 0;
      out_hs = exp_ov && out_ready;
      exp_done = out_hs && m_out == ENQLEN - 1;
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      if (exp_ov) chk("out_char", out_char, q[0]);
      chk("done", done, exp_done);
      chk("busy", busy, m_active);
      chk("err", err, m_err);
      if (done) n_done++;
      if (!m_active) begin
        if (start) begin
          m_active = 1;
          m_pw = passwd;
          m_i = 0;
          m_out = 0;
          m_err = 0;
        end
      end else begin
        if (out_hs) begin
          void'(q.pop_front());
          m_out++;
          if (exp_done) m_active = 0;
        end
        if (exp_ir && in_valid) begin
          q.push_back(enc_of(in_char, m_pw, m_i));
          m_err = m_err || in_char[7:4] > 9 || in_char[3:0] > 9 || dec(in_char) > 94;
          m_i++;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_msg(logic [8*PASSLEN-1:0] pw);
    passwd = pw;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send(logic [7:0] c);
    bit acc = 0;
    in_valid = 1;
    in_char = c;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    if (!acc) chk("send_timeout", 32'(acc), 1);
  endtask
  task automatic finish_msg();
    bit idle = 0;
    in_valid = 0;
    for (int n = 0; n < 20 && !idle; n++) begin
      @(negedge clk);
      idle = !busy;
      tick();
    end
    chk("drain_timeout", 32'(idle), 1);
  endtask
  initial begin
    int d0;
    logic [7:0] hold;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0;
    logic [7:0] hold;
    rst = 1;
    repeat (2) tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 0);
    out_ready = 1;
    d0 = n_done;
    start_msg(40'h0000000000);
    send(8'h10);
    chk("zero_pw_10", out_char, 8'h15);
    for (int i = 1; i < ENQLEN; i++) send(bcd((i * 11) % 95));
    finish_msg();
    chk("done_once", 32'(n_done - d0), 1);
    start_msg(40'h1200000000);
    send(8'h90);
    chk("pw12_90", out_char, 8'h12);
    for (int i = 1; i < ENQLEN; i++) send(bcd(i * 9 + 3));
    finish_msg();
    start_msg(40'h9999999999);
    send(8'h94);
    chk("pw99_i0", out_char, 8'h08);
    repeat (3) send(8'h00);
    send(8'h94);
    chk("pw99_i4", out_char, 8'h04);
    send(8'h94);
    chk("pw99_i5_wrap", out_char, 8'h08);
    for (int i = 6; i < ENQLEN; i++) send(bcd(i * 13));
    finish_msg();
    start_msg(40'h1234567890);
    for (int i = 0; i < 3; i++) send(bcd(20 + i * 7));
    start = 1;
    passwd = 40'h0000000000;
    send(8'h47);
    start = 0;
    out_ready = 0;
    in_char = 8'h55;
    hold = out_char;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", out_char, hold);
      chk("stall_valid", out_valid, 1);
    end
    tick();
    out_ready = 1;
    for (int i = 4; i < ENQLEN; i++) send(bcd(50 + i * 4));
    finish_msg();
    start_msg(40'h1122334455);
    send(8'h3A);
    chk("illegal_err", err, 1);
    chk("illegal_enc", out_char, 8'h56);
    for (int i = 1; i < ENQLEN; i++) send(bcd(i * 5));
    finish_msg();
    chk("err_sticky", err, 1);
    chk("idle_busy", busy, 0);
    start_msg(40'h1122334455);
    chk("err_cleared", err, 0);
    send(8'h01);
    send(8'hA0);
    send(8'h02);
    in_valid = 1;
    in_char = 8'h03;
    rst = 1;
    tick();
    rst = 0;
    in_valid = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_char", out_char, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    start_msg(40'h1122334455);
    send(8'h20);
    chk("restart_i0", out_char, 8'h36);
    for (int i = 1; i < ENQLEN; i++) send(bcd(i * 8));
    finish_msg();
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
